io_timer_6502: RTL and testbench

Memory-mapped I/O and timer responder on the `computer_8bit` 6502 bus. It sits beside the ROM and RAM, and the CPU is the only bus initiator. The block decodes a 16-byte window and serves CPU reads and writes from `ab`, `rw` and `dbo`. It provides two 8-bit GPIO ports and a 16-bit interval timer, and it drives the active-low `irq` input of `chip_6502`.

---
 rtl/computer_8bit_pkg.sv | 32 +++
 rtl/io_timer_t1.sv | 56 +++++
 rtl/io_timer_6502.sv | 137 +++++++++++++
 tb/tb_io_timer_6502.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/computer_8bit_pkg.sv
// rtl/computer_8bit_pkg.sv - shared register map for the computer_8bit I/O responders
package computer_8bit_pkg;

  // Register offsets within the 16-byte window (ab[3:0]).
  localparam logic [3:0] REG_ORA  = 4'h0;
  localparam logic [3:0] REG_DDRA = 4'h1;
  localparam logic [3:0] REG_ORB  = 4'h2;
  localparam logic [3:0] REG_DDRB = 4'h3;
  localparam logic [3:0] REG_T1LL = 4'h4;
  localparam logic [3:0] REG_T1LH = 4'h5;
  localparam logic [3:0] REG_T1CL = 4'h6;
  localparam logic [3:0] REG_T1CH = 4'h7;
  localparam logic [3:0] REG_ACR  = 4'h8;
  localparam logic [3:0] REG_IFR  = 4'h9;
  localparam logic [3:0] REG_IER  = 4'hA;

  // IFR/IER bit positions. Bit 0 is the timer source in both registers.
  localparam int IFR_T1  = 0;
  localparam int IFR_IRQ = 7;
  localparam int IER_SET = 7;

  // ACR bit selecting free-run (reload) instead of one-shot.
  localparam int ACR_FREERUN = 0;

  // Pins configured as inputs read the pad; pins configured as outputs read the register.
  function automatic logic [7:0] port_read(input logic [7:0] or_q,
                                           input logic [7:0] ddr,
                                           input logic [7:0] pins);
    return (or_q & ddr) | (pins & ~ddr);
  endfunction

endpackage

// File: rtl/io_timer_t1.sv
// rtl/io_timer_t1.sv - 16-bit interval timer core with reload latch
// Ports: clk/res_n clock and sync active-low reset; tick one bus-cycle strobe;
//   load T1LH write (reload and arm); freerun reload mode; ll_we/lh_we/wdata latch writes;
//   count live counter; latch reload value; underflow_set flag request this tick.
module io_timer_t1 (
  input  logic        clk,
  input  logic        res_n,
  input  logic        tick,
  input  logic        load,
  input  logic        freerun,
  input  logic        ll_we,
  input  logic        lh_we,
  input  logic [7:0]  wdata,
  output logic [15:0] count,
  output logic [15:0] latch,
  output logic        underflow_set
);

  logic [7:0] latch_l;
  logic [7:0] latch_h;
  logic       armed;

  assign latch = {latch_h, latch_l};

  // Only an armed timer raises the flag; an expired one-shot keeps counting silently.
  assign underflow_set = tick & armed & (count == 16'h0000);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      latch_l <= 8'h00;
      latch_h <= 8'h00;
      count   <= 16'h0000;
      armed   <= 1'b0;
    end else begin
      if (ll_we) latch_l <= wdata;
      if (lh_we) latch_h <= wdata;
      // A load on the underflow tick takes priority over the reload/decrement.
      if (load) begin
        count <= {wdata, latch_l};
        armed <= 1'b1;
      end else if (tick) begin
        if (count == 16'h0000) begin
          if (freerun) begin
            count <= latch;
          end else begin
            count <= 16'hFFFF;
            armed <= 1'b0;
          end
        end else begin
          count <= count - 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/io_timer_6502.sv
// rtl/io_timer_6502.sv - 6502 bus GPIO ports and interval timer responder
// Ports: CLOCK_50/res_n clock and sync active-low reset; phi 6502 bus clock;
//   ab/rw/dbo CPU address, direction and write data; rdata/rdata_oe read data and dbi ownership;
//   irq_n active-low interrupt; pa_in/pb_in pins; pa_out/pb_out output registers; pa_oe/pb_oe directions.
module io_timer_6502
  import computer_8bit_pkg::*;
#(
  parameter logic [15:0] BASE = 16'hD000
) (
  input  logic        CLOCK_50,
  input  logic        res_n,
  input  logic        phi,
  input  logic [15:0] ab,
  input  logic        rw,
  input  logic [7:0]  dbo,
  output logic [7:0]  rdata,
  output logic        rdata_oe,
  output logic        irq_n,
  input  logic [7:0]  pa_in,
  input  logic [7:0]  pb_in,
  output logic [7:0]  pa_out,
  output logic [7:0]  pb_out,
  output logic [7:0]  pa_oe,
  output logic [7:0]  pb_oe
);

  logic        phi_q;
  logic        tick;
  logic        sel;
  logic        wr;
  logic        rd;
  logic [3:0]  off;
  logic [7:0]  ora;
  logic [7:0]  ddra;
  logic [7:0]  orb;
  logic [7:0]  ddrb;
  logic        acr_freerun;
  logic        ifr_t1;
  logic [6:0]  ier;
  logic        t1_ll_we;
  logic        t1_lh_we;
  logic        t1_underflow_set;
  logic [15:0] t1_count;
  logic [15:0] t1_latch;
  logic        ifr_clr;
  logic [7:0]  rd_mux;

  // A phi fall ends the bus cycle; all side effects key off this single strobe.
  assign tick = phi_q & ~phi;
  assign sel  = (ab[15:4] == BASE[15:4]);
  assign off  = ab[3:0];
  assign wr   = tick & sel & ~rw;
  assign rd   = tick & sel & rw;

  assign t1_ll_we = wr & (off == REG_T1LL);
  assign t1_lh_we = wr & (off == REG_T1LH);
  assign ifr_clr  = (wr & (off == REG_IFR) & dbo[IFR_T1]) | (rd & (off == REG_T1CL));

  assign rdata_oe = sel & rw & phi_q;
  assign pa_out   = ora;
  assign pb_out   = orb;
  assign pa_oe    = ddra;
  assign pb_oe    = ddrb;

  io_timer_t1 u_t1 (
    .clk           (CLOCK_50),
    .res_n         (res_n),
    .tick          (tick),
    .load          (t1_lh_we),
    .freerun       (acr_freerun),
    .ll_we         (t1_ll_we),
    .lh_we         (t1_lh_we),
    .wdata         (dbo),
    .count         (t1_count),
    .latch         (t1_latch),
    .underflow_set (t1_underflow_set)
  );

  always_comb begin
    rd_mux = 8'h00;
    case (off)
      REG_ORA:  rd_mux = port_read(ora, ddra, pa_in);
      REG_DDRA: rd_mux = ddra;
      REG_ORB:  rd_mux = port_read(orb, ddrb, pb_in);
      REG_DDRB: rd_mux = ddrb;
      REG_T1LL: rd_mux = t1_latch[7:0];
      REG_T1LH: rd_mux = t1_latch[15:8];
      REG_T1CL: rd_mux = t1_count[7:0];
      REG_T1CH: rd_mux = t1_count[15:8];
      REG_ACR:  rd_mux[ACR_FREERUN] = acr_freerun;
      REG_IFR: begin
        rd_mux[IFR_T1]  = ifr_t1;
        rd_mux[IFR_IRQ] = ifr_t1 & ier[IFR_T1];
      end
      REG_IER:  rd_mux = {1'b1, ier};
      default:  rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!res_n) begin
      phi_q       <= 1'b0;
      ora         <= 8'h00;
      ddra        <= 8'h00;
      orb         <= 8'h00;
      ddrb        <= 8'h00;
      acr_freerun <= 1'b0;
      ifr_t1      <= 1'b0;
      ier         <= 7'h00;
      rdata       <= 8'h00;
      irq_n       <= 1'b1;
    end else begin
      phi_q <= phi;
      rdata <= sel ? rd_mux : 8'h00;
      irq_n <= ~(ifr_t1 & ier[IFR_T1]);
      if (wr) begin
        case (off)
          REG_ORA:  ora  <= dbo;
          REG_DDRA: ddra <= dbo;
          REG_ORB:  orb  <= dbo;
          REG_DDRB: ddrb <= dbo;
          REG_ACR:  acr_freerun <= dbo[ACR_FREERUN];
          REG_IER: begin
            if (dbo[IER_SET]) ier <= ier | dbo[6:0];
            else              ier <= ier & ~dbo[6:0];
          end
          default: ;
        endcase
      end
      // Reload beats underflow, and underflow beats a clear on the same tick.
      if (t1_lh_we)              ifr_t1 <= 1'b0;
      else if (t1_underflow_set) ifr_t1 <= 1'b1;
      else if (ifr_clr)          ifr_t1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_timer_6502.sv
// tb/tb_io_timer_6502.sv - scoreboard bench for io_timer_6502
module tb_io_timer_6502;

  localparam logic [15:0] BASE = 16'hD000;
  localparam logic [15:0] IDLE = 16'h0000;

  logic        clk;
  logic        res_n;
  logic        phi;
  logic [15:0] ab;
  logic        rw;
  logic [7:0]  dbo;
  logic [7:0]  rdata;
  logic        rdata_oe;
  logic        irq_n;
  logic [7:0]  pa_in;
  logic [7:0]  pb_in;
  logic [7:0]  pa_out;
  logic [7:0]  pb_out;
  logic [7:0]  pa_oe;
  logic [7:0]  pb_oe;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];

  // Reference model of the register file, advanced once per bus cycle.
  logic [7:0]  m_ora, m_ddra, m_orb, m_ddrb, m_ll, m_lh;
  logic [15:0] m_count;
  logic        m_armed, m_acr, m_ifr;
  logic [6:0]  m_ier;

  io_timer_6502 #(.BASE(BASE)) dut (
    .CLOCK_50 (clk),
    .res_n    (res_n),
    .phi      (phi),
    .ab       (ab),
    .rw       (rw),
    .dbo      (dbo),
    .rdata    (rdata),
    .rdata_oe (rdata_oe),
    .irq_n    (irq_n),
    .pa_in    (pa_in),
    .pb_in    (pb_in),
    .pa_out   (pa_out),
    .pb_out   (pb_out),
    .pa_oe    (pa_oe),
    .pb_oe    (pb_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic m_reset();
    m_ora = 0; m_ddra = 0; m_orb = 0; m_ddrb = 0; m_ll = 0; m_lh = 0;
    m_count = 0; m_armed = 0; m_acr = 0; m_ifr = 0; m_ier = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] off);
    case (off)
      4'h0: return (m_ora & m_ddra) | (pa_in & ~m_ddra);
      4'h1: return m_ddra;
      4'h2: return (m_orb & m_ddrb) | (pb_in & ~m_ddrb);
      4'h3: return m_ddrb;
      4'h4: return m_ll;
      4'h5: return m_lh;
      4'h6: return m_count[7:0];
      4'h7: return m_count[15:8];
      4'h8: return {7'b0, m_acr};
      4'h9: return {m_ifr & m_ier[0], 6'b0, m_ifr};
      4'hA: return {1'b1, m_ier};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_tick(input logic s, input logic r, input logic [3:0] off, input logic [7:0] d);
    logic ld, clr, uf;
    ld  = s && !r && off == 4'h5;
    clr = s && ((!r && off == 4'h9 && d[0]) || (r && off == 4'h6));
    uf  = 1'b0;
    if (ld) begin
      m_count = {d, m_ll};
      m_armed = 1'b1;
    end else if (m_count == 16'h0000) begin
      uf = m_armed;
      if (m_acr) m_count = {m_lh, m_ll};
      else begin m_count = 16'hFFFF; m_armed = 1'b0; end
    end else begin
      m_count = m_count - 16'd1;
    end
    if (ld) m_ifr = 1'b0;
    else if (uf) m_ifr = 1'b1;
    else if (clr) m_ifr = 1'b0;
    if (s && !r) begin
      case (off)
        4'h0: m_ora = d;
        4'h1: m_ddra = d;
        4'h2: m_orb = d;
        4'h3: m_ddrb = d;
        4'h4: m_ll = d;
        4'h5: m_lh = d;
        4'h8: m_acr = d[0];
        4'hA: m_ier = d[7] ? (m_ier | d[6:0]) : (m_ier & ~d[6:0]);
        default: ;
      endcase
    end
  endtask

  // One full phi period: phi high for two clocks, low for two; the tick lands on the third edge.
  task automatic bus_cycle(input logic [15:0] addr, input logic r, input logic [7:0] d);
    logic s;
    s = (addr[15:4] == BASE[15:4]);
    @(posedge clk); #1;
    ab = addr; rw = r; dbo = d; phi = 1'b1;
    if (s && r) exp_q.push_back(m_read(addr[3:0]));
    @(posedge clk);
    @(posedge clk); #1;
    phi = 1'b0;
    @(posedge clk);
    @(posedge clk);
    m_tick(s, r, addr[3:0], d);
    #1;
  endtask

  // Read-data scoreboard: one sample per read, just after phi falls and before the tick edge.
  always @(negedge clk) begin
    if (res_n && rdata_oe && !phi) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: rdata_oe=1 at ab=%h, required no read", ab);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL rdata ab=%h: got %h, required %h", ab, rdata, e);
        end
      end
    end
  end

  task automatic test_reset();
    res_n = 1'b0; phi = 1'b0; ab = IDLE; rw = 1'b1; dbo = 8'h00; pa_in = 8'h00; pb_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n: got %b, required 1", irq_n); end
    checks++; if (rdata_oe !== 1'b0) begin errors++; $display("FAIL reset_rdata_oe: got %b, required 0", rdata_oe); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h, required 00", rdata); end
    checks++; if (pa_oe !== 8'h00 || pb_oe !== 8'h00) begin errors++; $display("FAIL reset_oe: got %h/%h, required 00/00", pa_oe, pb_oe); end
    checks++; if (pa_out !== 8'h00 || pb_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h/%h, required 00/00", pa_out, pb_out); end
    res_n = 1'b1;
    m_reset();
    for (int i = 0; i <= 10; i++) begin
      bus_cycle(BASE + 16'(i), 1'b1, 8'h00);
      checks++;
      if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_read_irq_n off=%0d: got %b, required 1", i, irq_n); end
    end
  endtask

  task automatic test_gpio();
    pa_in = 8'h3C; pb_in = 8'hC3;
    bus_cycle(BASE + 16'h1, 1'b0, 8'hF0);
    bus_cycle(BASE + 16'h0, 1'b0, 8'hA5);
    bus_cycle(BASE + 16'h3, 1'b0, 8'h0F);
    bus_cycle(BASE + 16'h2, 1'b0, 8'h5A);
    checks++; if (pa_out !== 8'hA5) begin errors++; $display("FAIL gpio_pa_out: got %h, required a5", pa_out); end
    checks++; if (pa_oe !== 8'hF0) begin errors++; $display("FAIL gpio_pa_oe: got %h, required f0", pa_oe); end
    checks++; if (pb_out !== 8'h5A) begin errors++; $display("FAIL gpio_pb_out: got %h, required 5a", pb_out); end
    checks++; if (pb_oe !== 8'h0F) begin errors++; $display("FAIL gpio_pb_oe: got %h, required 0f", pb_oe); end
    bus_cycle(BASE + 16'h0, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h2, 1'b1, 8'h00);
    pa_in = 8'hFF;
    bus_cycle(BASE + 16'h0, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h1, 1'b1, 8'h00);
  endtask

  task automatic test_oneshot();
    int flags;
    bus_cycle(BASE + 16'hA, 1'b0, 8'h81);
    bus_cycle(BASE + 16'h8, 1'b0, 8'h00);
    bus_cycle(BASE + 16'h4, 1'b0, 8'h03);
    bus_cycle(BASE + 16'h5, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      bus_cycle(IDLE, 1'b1, 8'h00);
      checks++;
      if (irq_n !== (i == 4 ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL oneshot_irq_tick%0d: got %b, required %b", i, irq_n, (i == 4 ? 1'b0 : 1'b1));
      end
    end
    bus_cycle(BASE + 16'h9, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h6, 1'b1, 8'h00);
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL oneshot_t1cl_clear: got %b, required 1", irq_n); end
    flags = 0;
    for (int i = 0; i < 200; i++) begin
      bus_cycle(IDLE, 1'b1, 8'h00);
      if (irq_n !== 1'b1) flags++;
    end
    checks++; if (flags != 0) begin errors++; $display("FAIL oneshot_no_reflag: got %0d flagged ticks, required 0", flags); end
    bus_cycle(BASE + 16'h9, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h7, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h6, 1'b1, 8'h00);
  endtask

  task automatic test_freerun();
    bus_cycle(BASE + 16'h8, 1'b0, 8'h01);
    bus_cycle(BASE + 16'h4, 1'b0, 8'h02);
    bus_cycle(BASE + 16'h5, 1'b0, 8'h00);
    for (int round = 0; round < 4; round++) begin
      if (round > 0) begin
        bus_cycle(BASE + 16'h9, 1'b0, 8'h01);
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL freerun_clear r%0d: got %b, required 1", round, irq_n); end
      end
      for (int i = 0; i < (round == 0 ? 2 : 1); i++) begin
        bus_cycle(IDLE, 1'b1, 8'h00);
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL freerun_early r%0d: got %b, required 1", round, irq_n); end
      end
      bus_cycle(IDLE, 1'b1, 8'h00);
      checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL freerun_flag r%0d: got %b, required 0", round, irq_n); end
    end
    bus_cycle(BASE + 16'h9, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h9, 1'b0, 8'h01);
  endtask

  task automatic test_collisions();
    bus_cycle(BASE + 16'h5, 1'b0, 8'h00);
    bus_cycle(IDLE, 1'b1, 8'h00);
    bus_cycle(IDLE, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h5, 1'b0, 8'h00);
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL collide_load_irq: got %b, required 1", irq_n); end
    bus_cycle(BASE + 16'h9, 1'b1, 8'h00);
    bus_cycle(IDLE, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h6, 1'b1, 8'h00);
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL collide_t1cl_irq: got %b, required 0", irq_n); end
    bus_cycle(BASE + 16'h9, 1'b1, 8'h00);
    bus_cycle(BASE + 16'hA, 1'b0, 8'h01);
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL ier_clear_irq: got %b, required 1", irq_n); end
    bus_cycle(BASE + 16'hA, 1'b1, 8'h00);
    bus_cycle(BASE + 16'hA, 1'b0, 8'h81);
    bus_cycle(BASE + 16'h9, 1'b0, 8'h01);
  endtask

  task automatic test_decode();
    bus_cycle(BASE + 16'h10, 1'b0, 8'hFF);
    bus_cycle(BASE + 16'h11, 1'b0, 8'h00);
    bus_cycle(BASE + 16'h10, 1'b1, 8'h00);
    checks++; if (pa_out !== m_ora || pa_oe !== m_ddra) begin
      errors++; $display("FAIL decode_no_write: got %h/%h, required %h/%h", pa_out, pa_oe, m_ora, m_ddra);
    end
    bus_cycle(BASE + 16'hB, 1'b0, 8'hFF);
    bus_cycle(BASE + 16'hF, 1'b1, 8'h00);
    bus_cycle(BASE + 16'hB, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h0, 1'b1, 8'h00);
  endtask

  task automatic test_midreset();
    int waited;
    waited = 0;
    while (irq_n !== 1'b0 && waited < 8) begin
      bus_cycle(IDLE, 1'b1, 8'h00);
      waited++;
    end
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL midreset_setup_irq: got %b, required 0", irq_n); end
    @(posedge clk); #1;
    ab = BASE + 16'h5; rw = 1'b0; dbo = 8'h12; phi = 1'b1;
    @(posedge clk); #1;
    res_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL midreset_irq_n: got %b, required 1", irq_n); end
    checks++; if (pa_out !== 8'h00 || pa_oe !== 8'h00) begin errors++; $display("FAIL midreset_ports: got %h/%h, required 00/00", pa_out, pa_oe); end
    phi = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    res_n = 1'b1;
    m_reset();
    bus_cycle(BASE + 16'h6, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h7, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h5, 1'b1, 8'h00);
    bus_cycle(BASE + 16'h8, 1'b1, 8'h00);
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL midreset_after: got %b, required 1", irq_n); end
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_oneshot();
    test_freerun();
    test_collisions();
    test_decode();
    test_midreset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending reads, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
